// File: rtl/set_sequencer_pkg.sv
// Shared definitions for the set_sequencer table player.
// Holds the FSM state encoding and the minimum per-entry hold time.
package set_sequencer_pkg;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_PLAY = 1'b1
    } state_t;

    // A zero duration in the table is stretched to this many cycles.
    localparam int DUR_MIN = 1;

endpackage

// File: rtl/set_sequencer_if.sv
// Control, table-write and status bundle for set_sequencer.
// The tri-state bus itself stays a plain port on the top module.
interface set_sequencer_if #(
    parameter int N     = 1,
    parameter int AW    = 3,
    parameter int CNT_W = 16
);
    logic             wr_en;
    logic [AW-1:0]    wr_addr;
    logic [N-1:0]     wr_value;
    logic [N-1:0]     wr_oe;
    logic [CNT_W-1:0] wr_dur;
    logic [AW-1:0]    last_idx;
    logic             loop;
    logic             start;
    logic             stop;
    logic             set_en;
    logic [N-1:0]     set_value;
    logic [N-1:0]     set_oe;
    logic [N-1:0]     oe;
    logic             busy;
    logic             done;
    logic [AW-1:0]    cur_idx;

    modport master (
        output wr_en, wr_addr, wr_value, wr_oe, wr_dur, last_idx, loop,
               start, stop, set_en, set_value, set_oe,
        input  oe, busy, done, cur_idx
    );

    modport slave (
        input  wr_en, wr_addr, wr_value, wr_oe, wr_dur, last_idx, loop,
               start, stop, set_en, set_value, set_oe,
        output oe, busy, done, cur_idx
    );
endinterface

// File: rtl/set_seq_timer.sv
// Per-entry hold counter: loaded with the hold time, counts down while
// enabled, and flags the final cycle of the hold.
module set_seq_timer #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             en,
    input  logic [CNT_W-1:0] load_val,
    output logic             last
);
    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (en && cnt != '0) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign last = (cnt == CNT_W'(1));
endmodule

// File: rtl/set_sequencer.sv
// Plays a table of (value, oe, duration) entries onto a tri-state bus,
// one-shot or looping, with optional restore of the pre-run bus state.
module set_sequencer
    import set_sequencer_pkg::*;
#(
    parameter int           N          = 1,
    parameter int           DEPTH      = 8,
    parameter int           AW         = 3,
    parameter int           CNT_W      = 16,
    parameter int           RESTORE    = 1,
    parameter logic [N-1:0] IDLE_VALUE = '0
) (
    input  logic                clk,
    input  logic                rst,
    set_sequencer_if.slave      bus,
    output wire  [N-1:0]        signals
);
    logic [N-1:0]     tbl_value [DEPTH];
    logic [N-1:0]     tbl_oe    [DEPTH];
    logic [CNT_W-1:0] tbl_dur   [DEPTH];

    state_t           state, state_nxt;
    logic [N-1:0]     value, oe_r, save_value, save_oe;
    logic [AW-1:0]    idx, load_idx;
    logic             done_r, done_nxt;
    logic             load, save, set, finish_run;
    logic             timer_last;
    logic [CNT_W-1:0] hold;

    // Table is written in any state; entries are copied to the bus only on load,
    // so a displayed entry never changes mid-hold.
    always_ff @(posedge clk) begin
        if (bus.wr_en) begin
            tbl_value[bus.wr_addr] <= bus.wr_value;
            tbl_oe[bus.wr_addr]    <= bus.wr_oe;
            tbl_dur[bus.wr_addr]   <= bus.wr_dur;
        end
    end

    assign hold = (tbl_dur[load_idx] == '0) ? CNT_W'(DUR_MIN) : tbl_dur[load_idx];

    set_seq_timer #(.CNT_W(CNT_W)) u_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (load),
        .en       (state == ST_PLAY),
        .load_val (hold),
        .last     (timer_last)
    );

    always_ff @(posedge clk) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt  = state;
        load       = 1'b0;
        load_idx   = '0;
        save       = 1'b0;
        set        = 1'b0;
        finish_run = 1'b0;
        done_nxt   = 1'b0;
        unique case (state)
            ST_IDLE: begin
                // stop beats start, start beats set_en
                if (bus.start) begin
                    if (!bus.stop) begin
                        state_nxt = ST_PLAY;
                        load      = 1'b1;
                        save      = 1'b1;
                    end
                end else if (bus.set_en) begin
                    set = 1'b1;
                end
            end
            ST_PLAY: begin
                if (bus.stop) begin
                    state_nxt  = ST_IDLE;
                    finish_run = 1'b1;
                end else if (timer_last) begin
                    if (idx < bus.last_idx) begin
                        load     = 1'b1;
                        load_idx = idx + AW'(1);
                    end else if (bus.loop) begin
                        load = 1'b1;
                    end else begin
                        state_nxt  = ST_IDLE;
                        finish_run = 1'b1;
                        done_nxt   = 1'b1;
                    end
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            value      <= IDLE_VALUE;
            oe_r       <= '1;
            save_value <= IDLE_VALUE;
            save_oe    <= '1;
            idx        <= '0;
            done_r     <= 1'b0;
        end else begin
            done_r <= done_nxt;
            if (save) begin
                save_value <= value;
                save_oe    <= oe_r;
            end
            if (load) begin
                value <= tbl_value[load_idx];
                oe_r  <= tbl_oe[load_idx];
                idx   <= load_idx;
            end else if (finish_run && RESTORE != 0) begin
                value <= save_value;
                oe_r  <= save_oe;
            end else if (set) begin
                value <= bus.set_value;
                oe_r  <= bus.set_oe;
            end
        end
    end

    for (genvar i = 0; i < N; i++) begin : g_bus
        assign signals[i] = oe_r[i] ? value[i] : 1'bz;
    end

    assign bus.oe      = oe_r;
    assign bus.busy    = (state == ST_PLAY);
    assign bus.done    = done_r;
    assign bus.cur_idx = idx;
endmodule

// File: tb/tb_set_sequencer.sv
// Directed bench for set_sequencer: two instances (RESTORE=0 and RESTORE=1)
// checked each cycle against a cycles-remaining playback model plus literal pins.
module tb_set_sequencer;
    localparam logic [3:0] IDLE_V = 4'h9;

    logic clk, rst;
    logic wr_en, loop, start, stop, set_en;
    logic [2:0] wr_addr, last_idx;
    logic [3:0] wr_value, wr_oe, set_value, set_oe;
    logic [15:0] wr_dur;
    wire  [3:0] sig0, sig1;

    set_sequencer_if #(.N(4), .AW(3), .CNT_W(16)) i0 ();
    set_sequencer_if #(.N(4), .AW(3), .CNT_W(16)) i1 ();

    assign i0.wr_en = wr_en;       assign i1.wr_en = wr_en;
    assign i0.wr_addr = wr_addr;   assign i1.wr_addr = wr_addr;
    assign i0.wr_value = wr_value; assign i1.wr_value = wr_value;
    assign i0.wr_oe = wr_oe;       assign i1.wr_oe = wr_oe;
    assign i0.wr_dur = wr_dur;     assign i1.wr_dur = wr_dur;
    assign i0.last_idx = last_idx; assign i1.last_idx = last_idx;
    assign i0.loop = loop;         assign i1.loop = loop;
    assign i0.start = start;       assign i1.start = start;
    assign i0.stop = stop;         assign i1.stop = stop;
    assign i0.set_en = set_en;     assign i1.set_en = set_en;
    assign i0.set_value = set_value; assign i1.set_value = set_value;
    assign i0.set_oe = set_oe;     assign i1.set_oe = set_oe;

    set_sequencer #(.N(4), .DEPTH(8), .AW(3), .CNT_W(16), .RESTORE(0), .IDLE_VALUE(IDLE_V))
        dut0 (.clk(clk), .rst(rst), .bus(i0), .signals(sig0));
    set_sequencer #(.N(4), .DEPTH(8), .AW(3), .CNT_W(16), .RESTORE(1), .IDLE_VALUE(IDLE_V))
        dut1 (.clk(clk), .rst(rst), .bus(i1), .signals(sig1));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model: instance r has RESTORE = r.
    logic [3:0] m_val [2], m_oe [2], m_sv [2], m_so [2];
    logic       m_busy [2], m_done [2];
    int         m_idx [2], m_left [2];
    logic [3:0] mt_val [8], mt_oe [8];
    int         mt_dur [8];
    int         n_vec = 0, n_err = 0;

    task automatic enter(input int r, input int k);
        m_idx[r]  = k;
        m_val[r]  = mt_val[k];
        m_oe[r]   = mt_oe[k];
        m_left[r] = (mt_dur[k] == 0) ? 1 : mt_dur[k];
    endtask

    task automatic leave(input int r, input logic fin);
        m_busy[r] = 1'b0;
        m_done[r] = fin;
        if (r == 1) begin
            m_val[r] = m_sv[r];
            m_oe[r]  = m_so[r];
        end
    endtask

    always @(posedge clk) begin
        for (int r = 0; r < 2; r++) begin
            if (rst) begin
                m_val[r] = IDLE_V; m_oe[r] = 4'hF; m_busy[r] = 1'b0;
                m_done[r] = 1'b0; m_idx[r] = 0; m_left[r] = 0;
            end else begin
                m_done[r] = 1'b0;
                if (!m_busy[r]) begin
                    if (start) begin
                        if (!stop) begin
                            m_sv[r] = m_val[r]; m_so[r] = m_oe[r];
                            m_busy[r] = 1'b1;
                            enter(r, 0);
                        end
                    end else if (set_en) begin
                        m_val[r] = set_value; m_oe[r] = set_oe;
                    end
                end else if (stop) leave(r, 1'b0);
                else if (m_left[r] > 1) m_left[r] = m_left[r] - 1;
                else if (m_idx[r] < int'(last_idx)) enter(r, m_idx[r] + 1);
                else if (loop) enter(r, 0);
                else leave(r, 1'b1);
            end
        end
        if (wr_en) begin
            mt_val[wr_addr] = wr_value;
            mt_oe[wr_addr]  = wr_oe;
            mt_dur[wr_addr] = int'(wr_dur);
        end
    end

    task automatic check_model();
        logic [3:0] a_sig, a_oe;
        logic [13:0] got, exp;
        for (int r = 0; r < 2; r++) begin
            a_sig = (r == 1) ? sig1 : sig0;
            a_oe  = (r == 1) ? i1.oe : i0.oe;
            got = {a_oe, a_sig & a_oe, (r == 1) ? i1.busy : i0.busy,
                   (r == 1) ? i1.done : i0.done, (r == 1) ? i1.cur_idx : i0.cur_idx};
            exp = {m_oe[r], m_val[r] & m_oe[r], m_busy[r], m_done[r], 3'(m_idx[r])};
            n_vec++;
            if (got !== exp) begin
                n_err++;
                $display("FAIL model_r%0d t=%0t got oe/val/busy/done/idx=%h want %h", r, $time, got, exp);
            end
        end
    endtask

    // Every cycle passes through here, so the model compare runs each cycle.
    task automatic tick();
        @(negedge clk);
        check_model();
    endtask

    task automatic lit(input string name, input int r, input logic [3:0] v, input logic [3:0] o,
                       input logic b, input logic d, input int ix);
        logic [3:0] a_sig, a_oe;
        logic [2:0] a_ix;
        logic [9:0] got, exp;
        a_sig = (r == 1) ? sig1 : sig0;
        a_oe  = (r == 1) ? i1.oe : i0.oe;
        a_ix  = (r == 1) ? i1.cur_idx : i0.cur_idx;
        got = {a_oe, a_sig & a_oe, (r == 1) ? i1.busy : i0.busy, (r == 1) ? i1.done : i0.done};
        exp = {o, v & o, b, d};
        n_vec++;
        if (got !== exp || (ix >= 0 && a_ix !== 3'(ix))) begin
            n_err++;
            $display("FAIL %s r%0d got oe/val/busy/done=%h idx=%0d want %h idx=%0d",
                     name, r, got, a_ix, exp, ix);
        end
    endtask

    task automatic wr(input int a, input logic [3:0] v, input logic [3:0] o, input int d);
        wr_en = 1'b1; wr_addr = 3'(a); wr_value = v; wr_oe = o; wr_dur = 16'(d);
        tick();
        wr_en = 1'b0;
    endtask

    task automatic preset5();
        set_en = 1'b1; set_value = 4'h5; set_oe = 4'hF;
        tick();
        set_en = 1'b0;
        lit("preset", 1, 4'h5, 4'hF, 1'b0, 1'b0, -1);
    endtask

    logic [3:0] pat [13];

    initial begin
        rst = 1'b1; wr_en = 0; loop = 0; start = 0; stop = 0; set_en = 0;
        wr_addr = 0; last_idx = 0; wr_value = 0; wr_oe = 0; set_value = 0; set_oe = 0; wr_dur = 0;
        tick(); tick();
        lit("reset", 1, IDLE_V, 4'hF, 1'b0, 1'b0, 0);
        lit("reset", 0, IDLE_V, 4'hF, 1'b0, 1'b0, 0);
        rst = 1'b0;
        wr(0, 4'h3, 4'hF, 2);
        wr(1, 4'hC, 4'hF, 3);
        preset5();

        // one-shot, two entries
        last_idx = 3'd1; loop = 1'b0; start = 1'b1;
        tick(); start = 1'b0;
        for (int i = 0; i < 2; i++) begin lit("oneshot_e0", 1, 4'h3, 4'hF, 1'b1, 1'b0, 0); tick(); end
        for (int i = 0; i < 3; i++) begin lit("oneshot_e1", 1, 4'hC, 4'hF, 1'b1, 1'b0, 1); tick(); end
        lit("restore", 1, 4'h5, 4'hF, 1'b0, 1'b1, -1);
        lit("hold_last", 0, 4'hC, 4'hF, 1'b0, 1'b1, -1);
        tick();
        lit("done_once", 1, 4'h5, 4'hF, 1'b0, 1'b0, -1);

        // looping, then stop during entry 1
        pat = '{4'h3, 4'h3, 4'hC, 4'hC, 4'hC, 4'h3, 4'h3, 4'hC, 4'hC, 4'hC, 4'h3, 4'h3, 4'hC};
        loop = 1'b1; start = 1'b1;
        tick(); start = 1'b0;
        for (int i = 0; i < 13; i++) begin
            lit("loop", 1, pat[i], 4'hF, 1'b1, 1'b0, -1);
            if (i == 12) stop = 1'b1;
            tick();
        end
        stop = 1'b0;
        lit("stop_restore", 1, 4'h5, 4'hF, 1'b0, 1'b0, -1);
        lit("stop_hold", 0, 4'hC, 4'hF, 1'b0, 1'b0, -1);

        // start with stop (and set_en) in IDLE: nothing happens
        start = 1'b1; stop = 1'b1; set_en = 1'b1; set_value = 4'h7; set_oe = 4'h1;
        tick();
        start = 1'b0; stop = 1'b0; set_en = 1'b0;
        lit("start_stop", 1, 4'h5, 4'hF, 1'b0, 1'b0, -1);
        tick();

        // single entry, zero duration, partial oe
        preset5();
        wr(0, 4'hA, 4'h3, 0);
        last_idx = 3'd0; loop = 1'b0; start = 1'b1;
        tick(); start = 1'b0;
        lit("dur0", 1, 4'hA, 4'h3, 1'b1, 1'b0, 0);
        tick();
        lit("dur0_end", 1, 4'h5, 4'hF, 1'b0, 1'b1, -1);
        lit("dur0_hold", 0, 4'hA, 4'h3, 1'b0, 1'b1, -1);

        // rewrites during play
        preset5();
        wr(0, 4'h3, 4'hF, 4);
        wr(1, 4'hC, 4'hF, 3);
        last_idx = 3'd1; loop = 1'b1; start = 1'b1;
        tick(); start = 1'b0;
        wr_en = 1'b1; wr_addr = 3'd1; wr_value = 4'h6; wr_oe = 4'hF; wr_dur = 16'd3;
        lit("rw_e0", 1, 4'h3, 4'hF, 1'b1, 1'b0, 0);
        tick();
        wr_addr = 3'd0; wr_value = 4'hE; wr_dur = 16'd4;
        lit("rw_e0", 1, 4'h3, 4'hF, 1'b1, 1'b0, 0);
        tick(); wr_en = 1'b0;
        lit("rw_e0_kept", 1, 4'h3, 4'hF, 1'b1, 1'b0, 0);
        tick();
        tick();
        lit("rw_e1_new", 1, 4'h6, 4'hF, 1'b1, 1'b0, 1);
        tick(); tick(); tick();
        lit("rw_e0_new", 1, 4'hE, 4'hF, 1'b1, 1'b0, 0);
        stop = 1'b1;
        tick(); stop = 1'b0;
        lit("rw_stop", 1, 4'h5, 4'hF, 1'b0, 1'b0, -1);

        // reset mid-run, then a fresh run restores to the reset value
        start = 1'b1;
        tick(); start = 1'b0;
        tick(); tick();
        rst = 1'b1;
        tick(); rst = 1'b0;
        lit("rst_mid", 1, IDLE_V, 4'hF, 1'b0, 1'b0, 0);
        lit("rst_mid", 0, IDLE_V, 4'hF, 1'b0, 1'b0, 0);
        loop = 1'b0; start = 1'b1;
        tick(); start = 1'b0;
        lit("post_rst", 1, 4'hE, 4'hF, 1'b1, 1'b0, 0);
        for (int i = 0; i < 7; i++) tick();
        lit("post_rst_restore", 1, IDLE_V, 4'hF, 1'b0, 1'b1, -1);
        tick(); tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
